// File: rtl/n64_pi_prefetch.sv
`timescale 1ns/1ps
// n64_pi_prefetch: read-ahead line buffer between the PI bus master and the
// SDRAM arbiter. Reads with id PREFETCH_ID are served from one buffered line
// of LINE_WORDS halfwords, refilled on a miss by sequential single-halfword
// fetches. Writes go straight through and patch the buffered copy on a tag
// match. Every other id passes straight through.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               one-cycle line invalidate
//   req/req_*           upstream request (held until ack)
//   ack, rdata          upstream one-cycle completion and read data
//   mem_*  (out)        downstream request, one outstanding at a time
//   mem_ack, mem_rdata  downstream completion and read data
module n64_pi_prefetch #(
    parameter int unsigned LINE_WORDS  = 8,
    parameter int unsigned ID_W        = 3,
    parameter int unsigned PREFETCH_ID = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req,
    input  logic            req_write,
    input  logic [ID_W-1:0] req_id,
    input  logic [31:0]     req_address,
    input  logic [15:0]     req_wdata,
    output logic            ack,
    output logic [15:0]     rdata,
    output logic            mem_request,
    output logic            mem_write,
    output logic [ID_W-1:0] mem_id,
    output logic [31:0]     mem_address,
    output logic [15:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata
);

    localparam int unsigned LB    = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W = 31 - LB;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_PASS  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             line_valid_q, line_valid_d;
    logic             flush_seen_q, flush_seen_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [LB-1:0]    req_idx_q, req_idx_d;
    logic [LB-1:0]    fill_idx_q, fill_idx_d;
    logic             ack_q, ack_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             mem_request_q, mem_request_d;
    logic             mem_write_q, mem_write_d;
    logic [ID_W-1:0]  mem_id_q, mem_id_d;
    logic [31:0]      mem_address_q, mem_address_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;

    logic [15:0]      line_buf_q [LINE_WORDS];
    logic             buf_we;
    logic [LB-1:0]    buf_widx;
    logic [15:0]      buf_wdata;

    logic [TAG_W-1:0] req_tag;
    logic [LB-1:0]    req_idx;
    logic             req_prefetch;
    logic             tag_hit;
    logic             accept;

    assign req_tag      = req_address[31:LB+1];
    assign req_idx      = req_address[LB:1];
    assign req_prefetch = (req_id == ID_W'(PREFETCH_ID));
    assign tag_hit      = line_valid_q && (req_tag == tag_q);
    // A req still high during the ack cycle is the tail of the finished one.
    assign accept       = req && !ack_q;

    // Next-state, output and buffer-write decisions
    always_comb begin
        state_d       = state_q;
        line_valid_d  = line_valid_q;
        flush_seen_d  = flush_seen_q;
        tag_d         = tag_q;
        req_idx_d     = req_idx_q;
        fill_idx_d    = fill_idx_q;
        ack_d         = 1'b0;
        rdata_d       = 16'h0000;
        mem_request_d = mem_request_q;
        mem_write_d   = mem_write_q;
        mem_id_d      = mem_id_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        buf_we        = 1'b0;
        buf_widx      = fill_idx_q;
        buf_wdata     = mem_rdata;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_prefetch && !req_write) begin
                        if (tag_hit && !flush) begin
                            ack_d   = 1'b1;
                            rdata_d = line_buf_q[req_idx];
                        end else begin
                            state_d       = S_FILL;
                            tag_d         = req_tag;
                            req_idx_d     = req_idx;
                            line_valid_d  = 1'b0;
                            flush_seen_d  = flush;
                            fill_idx_d    = '0;
                            mem_request_d = 1'b1;
                            mem_write_d   = 1'b0;
                            mem_id_d      = req_id;
                            mem_address_d = {req_tag, (LB+1)'(0)};
                        end
                    end else begin
                        state_d       = (req_prefetch) ? S_WRITE : S_PASS;
                        mem_request_d = 1'b1;
                        mem_write_d   = req_write;
                        mem_id_d      = req_id;
                        mem_address_d = req_address & ~32'h1;
                        mem_wdata_d   = req_wdata;
                        // Keep the buffered copy coherent with the write-through.
                        if (req_prefetch && tag_hit) begin
                            buf_we    = 1'b1;
                            buf_widx  = req_idx;
                            buf_wdata = req_wdata;
                        end
                    end
                end
            end

            S_FILL: begin
                if (flush) begin
                    flush_seen_d = 1'b1;
                end
                if (mem_request_q) begin
                    if (mem_ack) begin
                        mem_request_d = 1'b0;
                        buf_we        = 1'b1;
                        if (fill_idx_q == req_idx_q) begin
                            ack_d   = 1'b1;
                            rdata_d = mem_rdata;
                        end
                        if (fill_idx_q == LB'(LINE_WORDS - 1)) begin
                            line_valid_d = !(flush_seen_q || flush);
                            state_d      = S_IDLE;
                        end else begin
                            fill_idx_d = fill_idx_q + LB'(1);
                        end
                    end
                end else begin
                    // One idle cycle after each mem_ack, then the next word.
                    mem_request_d = 1'b1;
                    mem_address_d = {tag_q, fill_idx_q, 1'b0};
                end
            end

            S_WRITE, S_PASS: begin
                if (mem_request_q && mem_ack) begin
                    mem_request_d = 1'b0;
                    mem_write_d   = 1'b0;
                    ack_d         = 1'b1;
                    rdata_d       = (state_q == S_PASS && !mem_write_q) ? mem_rdata : 16'h0000;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            line_valid_d = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            line_valid_q  <= 1'b0;
            flush_seen_q  <= 1'b0;
            tag_q         <= '0;
            req_idx_q     <= '0;
            fill_idx_q    <= '0;
            ack_q         <= 1'b0;
            rdata_q       <= 16'h0000;
            mem_request_q <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_id_q      <= '0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            line_valid_q  <= line_valid_d;
            flush_seen_q  <= flush_seen_d;
            tag_q         <= tag_d;
            req_idx_q     <= req_idx_d;
            fill_idx_q    <= fill_idx_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            mem_request_q <= mem_request_d;
            mem_write_q   <= mem_write_d;
            mem_id_q      <= mem_id_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Line storage: no reset, only read behind line_valid
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf_q[buf_widx] <= buf_wdata;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign mem_request = mem_request_q;
    assign mem_write   = mem_write_q;
    assign mem_id      = mem_id_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
